// File: rtl/inst_queue_param_if.sv
// Fetch-side push, decode-side dispatch and back-pressure signals of the instruction queue.
// The slave modport is the queue's view; master is the surrounding pipeline's view.
interface inst_queue_param_if #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CW         = 5
);
  logic                  rdy;
  logic                  flush;
  logic                  rob_full;
  logic                  rs_full;
  logic                  lsb_full;
  logic                  if_valid;
  logic [INST_WIDTH-1:0] if_inst;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_pred_jump;
  logic [ADDR_WIDTH-1:0] if_pred_pc;
  logic                  iq_full;
  logic                  iq_almost_full;
  logic [CW-1:0]         iq_count;
  logic                  id_valid;
  logic [INST_WIDTH-1:0] id_inst;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic                  id_pred_jump;
  logic [ADDR_WIDTH-1:0] id_pred_pc;

  // Push: the queue takes if_* on any edge where if_valid=1, rdy=1, flush=0 and iq_full=0;
  // there is no ready signal, the fetcher must watch iq_full. Dispatch: id_valid is a
  // one-cycle pulse per instruction with no ready back; downstream fullness gates it instead.
  modport slave (
    input  rdy, flush, rob_full, rs_full, lsb_full,
    input  if_valid, if_inst, if_pc, if_pred_jump, if_pred_pc,
    output iq_full, iq_almost_full, iq_count,
    output id_valid, id_inst, id_pc, id_pred_jump, id_pred_pc
  );

  modport master (
    output rdy, flush, rob_full, rs_full, lsb_full,
    output if_valid, if_inst, if_pc, if_pred_jump, if_pred_pc,
    input  iq_full, iq_almost_full, iq_count,
    input  id_valid, id_inst, id_pc, id_pred_jump, id_pred_pc
  );
endinterface

// File: rtl/inst_queue_param.sv
// Parametrised in-order instruction queue between fetcher and decoder, with flush,
// almost-full warning and dispatch gated by ROB/RS/LSB fullness of the head's class.
module inst_queue_param #(
  parameter int DEPTH      = 16,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int AF_MARGIN  = 2
) (
  input  logic                clk,
  input  logic                rst,
  inst_queue_param_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred_jump;
    logic [ADDR_WIDTH-1:0] pred_pc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          id_valid_q, id_valid_d;
  entry_t        id_q, id_d;

  entry_t head_entry, wr_entry;
  logic   full, empty, is_lsb, launch, push, push_en;

  always_comb begin
    head_entry = mem_q[head_q];
    wr_entry   = '{inst: bus.if_inst, pc: bus.if_pc,
                   pred_jump: bus.if_pred_jump, pred_pc: bus.if_pred_pc};
    full       = (count_q == CW'(DEPTH));
    empty      = (count_q == '0);
    is_lsb     = (head_entry.inst[6:0] == OP_LOAD) || (head_entry.inst[6:0] == OP_STORE);
    launch     = !empty && !bus.rob_full && (is_lsb ? !bus.lsb_full : !bus.rs_full);
    // Full check uses the occupancy before this edge: a pop never frees a slot for a same-edge push.
    push       = bus.if_valid && !full;
    push_en    = push && bus.rdy && !bus.flush;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    id_valid_d = id_valid_q;
    id_d       = id_q;
    if (bus.flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      id_valid_d = 1'b0;
    end else if (bus.rdy) begin
      id_valid_d = launch;
      if (launch) begin
        id_d   = head_entry;
        head_d = head_q + 1'b1;
      end
      if (push) tail_d = tail_q + 1'b1;
      if (push && !launch)      count_d = count_q + 1'b1;
      else if (launch && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      id_valid_q <= 1'b0;
      id_q       <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      id_valid_q <= id_valid_d;
      id_q       <= id_d;
    end
  end

  // Storage needs no reset: only entries between head and tail are ever read out.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[tail_q] <= wr_entry;
  end

  assign bus.iq_full        = full;
  assign bus.iq_almost_full = (count_q >= CW'(DEPTH - AF_MARGIN));
  assign bus.iq_count       = count_q;
  assign bus.id_valid       = id_valid_q;
  assign bus.id_inst        = id_q.inst;
  assign bus.id_pc          = id_q.pc;
  assign bus.id_pred_jump   = id_q.pred_jump;
  assign bus.id_pred_pc     = id_q.pred_pc;
endmodule

// File: tb/tb_inst_queue_param.sv
// Bench for inst_queue_param: vector table, directed corner sequences and random traffic
// compared against a queue-based reference model.
module tb_inst_queue_param;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;
  localparam int IW    = 32;
  localparam int AW    = 32;
  localparam int CW    = 5;
  localparam int EW    = IW + AW + 1 + AW;
  localparam logic [31:0] ALU = 32'h0000_0033;
  localparam logic [31:0] LD  = 32'h0000_0003;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_queue_param_if #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .CW(CW)) bus ();

  inst_queue_param #(.DEPTH(DEPTH), .INST_WIDTH(IW), .ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: the queue contents in order plus the last dispatched record.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] m_id;
  logic          m_valid;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          if_valid;
    logic [31:0]   pc;
    logic [CW-1:0] exp_count;
    logic          exp_valid;
    logic [31:0]   exp_pc;
  } vec_t;
  vec_t vecs[5];

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic logic is_mem_op(logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    return (op == 7'b0000011) || (op == 7'b0100011);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 3))
      0:       return {r[31:7], 7'b0000011};
      1:       return {r[31:7], 7'b0100011};
      2:       return {r[31:7], 7'b0110011};
      default: return r;
    endcase
  endfunction

  task automatic set_push(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    bus.if_valid     = v;
    bus.if_inst      = inst;
    bus.if_pc        = pc;
    bus.if_pred_jump = pc[2];
    bus.if_pred_pc   = pc + 32'h40;
  endtask

  task automatic compare_model();
    chk("iq_count", bus.iq_count, exp_q.size());
    chk("iq_full", bus.iq_full, exp_q.size() == DEPTH);
    chk("iq_almost_full", bus.iq_almost_full, exp_q.size() >= DEPTH - AFM);
    chk("id_valid", bus.id_valid, m_valid);
    chk("id_fields", {bus.id_inst, bus.id_pc, bus.id_pred_jump, bus.id_pred_pc}, m_id);
  endtask

  // Apply one clock edge with the currently driven inputs, advance the model, then compare.
  task automatic tick();
    logic [EW-1:0] ent;
    logic [EW-1:0] front;
    logic          psh, lch;
    ent = {bus.if_inst, bus.if_pc, bus.if_pred_jump, bus.if_pred_pc};
    if (bus.flush) begin
      exp_q.delete();
      m_valid = 1'b0;
    end else if (bus.rdy) begin
      psh = bus.if_valid && (exp_q.size() < DEPTH);
      lch = 1'b0;
      if (exp_q.size() > 0) begin
        front = exp_q[0];
        lch = !bus.rob_full && (is_mem_op(front[EW-1 -: IW]) ? !bus.lsb_full : !bus.rs_full);
      end
      m_valid = lch;
      if (lch) m_id = exp_q.pop_front();
      if (psh) exp_q.push_back(ent);
    end
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_id    = '0;
    m_valid = 1'b0;
  endtask

  initial begin
    bus.rdy = 1'b1; bus.flush = 1'b0;
    bus.rob_full = 1'b0; bus.rs_full = 1'b0; bus.lsb_full = 1'b0;
    set_push(1'b0, ALU, 32'h0);
    model_reset();

    vecs[0] = '{1'b1, 32'h0, 5'd1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h4, 5'd1, 1'b1, 32'h0};
    vecs[2] = '{1'b1, 32'h8, 5'd1, 1'b1, 32'h4};
    vecs[3] = '{1'b0, 32'h0, 5'd0, 1'b1, 32'h8};
    vecs[4] = '{1'b0, 32'h0, 5'd0, 1'b0, 32'h8};

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_count", bus.iq_count, 0);
    chk("rst_id_valid", bus.id_valid, 0);
    chk("rst_id_pc", bus.id_pc, 0);
    chk("rst_full", bus.iq_full, 0);
    chk("rst_almost_full", bus.iq_almost_full, 0);
    rst = 1'b0;

    // Three ALU pushes, all fulls low
    for (int i = 0; i < 5; i++) begin
      set_push(vecs[i].if_valid, ALU, vecs[i].pc);
      tick();
      chk("vec_count", bus.iq_count, vecs[i].exp_count);
      chk("vec_id_valid", bus.id_valid, vecs[i].exp_valid);
      chk("vec_id_pc", bus.id_pc, vecs[i].exp_pc);
    end

    // Fill to full under rob_full (pointers start mid-array, so this wraps)
    bus.rob_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_push(1'b1, ALU, 32'h1000 + 32'(i * 4));
      tick();
      if (i == 12) chk("af_at_13", bus.iq_almost_full, 0);
      if (i == 13) chk("af_at_14", bus.iq_almost_full, 1);
      if (i == 14) chk("full_at_15", bus.iq_full, 0);
      if (i == 15) chk("full_at_16", bus.iq_full, 1);
    end
    set_push(1'b1, ALU, 32'hdead_0000);
    tick();
    chk("overflow_count", bus.iq_count, 16);
    bus.rob_full = 1'b0;
    set_push(1'b0, ALU, 32'h0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_valid", bus.id_valid, 1);
      chk("drain_pc", bus.id_pc, 32'h1000 + 32'(i * 4));
    end
    tick();
    chk("drain_empty", bus.iq_count, 0);
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, ALU, 32'h2000 + 32'(i * 4));
      tick();
    end
    set_push(1'b0, ALU, 32'h0);
    repeat (2) tick();

    // Load at head blocked by lsb_full stalls the younger ALU op
    bus.lsb_full = 1'b1;
    set_push(1'b1, LD, 32'h3000);
    tick();
    set_push(1'b1, ALU, 32'h3004);
    tick();
    set_push(1'b0, ALU, 32'h0);
    repeat (3) begin
      tick();
      chk("lsb_block_valid", bus.id_valid, 0);
      chk("lsb_block_count", bus.iq_count, 2);
    end
    bus.lsb_full = 1'b0;
    tick();
    chk("load_first", bus.id_pc, 32'h3000);
    tick();
    chk("alu_second", bus.id_pc, 32'h3004);
    tick();

    // Simultaneous push and launch at count 5, then at full
    bus.rob_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_push(1'b1, ALU, 32'h4000 + 32'(i * 4));
      tick();
    end
    bus.rob_full = 1'b0;
    set_push(1'b1, ALU, 32'h4014);
    tick();
    chk("both_count5", bus.iq_count, 5);
    chk("both_valid", bus.id_valid, 1);
    chk("both_pc", bus.id_pc, 32'h4000);
    bus.rob_full = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_push(1'b1, ALU, 32'h4100 + 32'(i * 4));
      tick();
    end
    bus.rob_full = 1'b0;
    set_push(1'b1, ALU, 32'hbeef_0000);
    tick();
    chk("full_both_count", bus.iq_count, 15);
    chk("full_both_valid", bus.id_valid, 1);

    // Flush wins over rdy=0 and a concurrent push
    bus.flush = 1'b1;
    set_push(1'b0, ALU, 32'h0);
    tick();
    bus.flush = 1'b0;
    bus.rob_full = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_push(1'b1, ALU, 32'h5000 + 32'(i * 4));
      tick();
    end
    bus.flush = 1'b1;
    bus.rdy = 1'b0;
    set_push(1'b1, ALU, 32'h5100);
    tick();
    chk("flush_count", bus.iq_count, 0);
    chk("flush_valid", bus.id_valid, 0);
    chk("flush_full", bus.iq_full, 0);
    bus.flush = 1'b0;
    bus.rdy = 1'b1;
    bus.rob_full = 1'b0;
    set_push(1'b1, ALU, 32'h5200);
    tick();
    set_push(1'b0, ALU, 32'h0);
    tick();
    chk("post_flush_valid", bus.id_valid, 1);
    chk("post_flush_pc", bus.id_pc, 32'h5200);

    // rdy=0 holds state with count 9 and id_valid high
    bus.rob_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_push(1'b1, ALU, 32'h6000 + 32'(i * 4));
      tick();
    end
    bus.rob_full = 1'b0;
    set_push(1'b0, ALU, 32'h0);
    tick();
    bus.rdy = 1'b0;
    set_push(1'b1, ALU, 32'h6100);
    repeat (3) begin
      tick();
      chk("hold_count", bus.iq_count, 9);
      chk("hold_valid", bus.id_valid, 1);
      chk("hold_pc", bus.id_pc, 32'h6000);
    end

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", bus.iq_count, 0);
    chk("async_rst_valid", bus.id_valid, 0);
    chk("async_rst_pc", bus.id_pc, 0);
    model_reset();
    bus.rdy = 1'b1;
    set_push(1'b0, ALU, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_model();

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bus.rdy      = ($urandom_range(0, 9) != 0);
      bus.flush    = ($urandom_range(0, 39) == 0);
      bus.rob_full = ($urandom_range(0, 3) == 0);
      bus.rs_full  = ($urandom_range(0, 3) == 0);
      bus.lsb_full = ($urandom_range(0, 2) == 0);
      bus.if_valid     = ($urandom_range(0, 9) < 6);
      bus.if_inst      = rand_inst();
      bus.if_pc        = $urandom();
      bus.if_pred_jump = $urandom_range(0, 1) == 1;
      bus.if_pred_pc   = $urandom();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
